// File: rtl/masked_prng_feed.sv
// Fresh-randomness feed for 3-share masked SKINNY S-box lanes: a seeded 64-bit LFSR
// advanced 16*NUM_SBOX steps per consumed word. Optional macro PRNG_ZERO_LOCK_EN remaps a zero seed to 1.
module masked_prng_feed #(
    parameter int NUM_SBOX      = 1,
    parameter int WARMUP_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    seed_load,
    input  logic [63:0]             seed,
    input  logic                    rnd_ready,
    output logic                    rnd_valid,
    output logic [12*NUM_SBOX-1:0]  rnd_r,
    output logic [4*NUM_SBOX-1:0]   rnd_klmn,
    output logic                    busy
);

    localparam int         STEPS     = 16 * NUM_SBOX;
    localparam logic [7:0] WARM_LAST = (WARMUP_CYCLES > 0) ? 8'(WARMUP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] s_q, s_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [63:0] s_adv;
    logic [63:0] load_value;

    // One full advance: STEPS chained shifts of x^64+x^63+x^61+x^60+1.
    function automatic logic [63:0] lfsr_advance(input logic [63:0] s);
        logic [63:0] v;
        v = s;
        for (int i = 0; i < STEPS; i++) begin
            v = {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
        end
        return v;
    endfunction

    // Seed value actually written into the LFSR on a load.
    always_comb begin
`ifdef PRNG_ZERO_LOCK_EN
        if (seed == 64'd0) begin
            load_value = 64'h0000_0000_0000_0001;
        end else begin
            load_value = seed;
        end
`else
        load_value = seed;
`endif
    end

    // Next-state logic; a seed load overrides every state and drops any pending consume.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        s_adv   = lfsr_advance(s_q);
        if (seed_load) begin
            s_d   = load_value;
            cnt_d = 8'd0;
            if (WARMUP_CYCLES == 0) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_WARMUP;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_WARMUP: begin
                    s_d   = s_adv;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == WARM_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_WARMUP;
                    end
                end
                ST_RUN: begin
                    if (rnd_ready) begin
                        s_d = s_adv;
                    end else begin
                        s_d = s_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    s_d     = s_q;
                    cnt_d   = cnt_q;
                end
            endcase
        end
    end

    // State, LFSR and warm-up counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= 64'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rnd_valid = (state_q == ST_RUN);
    assign busy      = (state_q == ST_WARMUP);

    // Lane k takes the 16-bit slice k of the registered state: low 12 bits r, top 4 bits klmn.
    for (genvar k = 0; k < NUM_SBOX; k++) begin : g_lane
        assign rnd_r[12*k +: 12]   = s_q[16*k +: 12];
        assign rnd_klmn[4*k +: 4]  = s_q[16*k + 12 +: 4];
    end

endmodule
